iwdg: RTL and testbench

//  Independent watchdog (IWDG) for the SoC. After the start key, a prescaled
//  12-bit down-counter runs; firmware must write the reload key before the

---
 rtl/iwdg_pkg.sv | 21 ++
 rtl/iwdg_prescaler.sv | 31 +++
 rtl/iwdg.sv | 93 +++++++++
 tb/tb_iwdg.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iwdg_pkg.sv
// rtl/iwdg_pkg.sv - shared keys, widths and prescaler divide helper for the independent watchdog
package iwdg_pkg;

  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
  localparam logic [15:0] KEY_UNLOCK = 16'h5555;

  localparam int PR_W    = 3;
  localparam int RLR_W   = 12;
  localparam int DIV_W   = 9;
  localparam int PRESC_W = DIV_W - 1;

  // Divide is 4 << pr; codes 6 and 7 saturate at 256.
  function automatic logic [DIV_W-1:0] pr_to_div(input logic [PR_W-1:0] pr);
    logic [DIV_W-1:0] d;
    if (pr >= 3'd6) d = 9'd256;
    else            d = 9'd4 << pr;
    return d;
  endfunction

endpackage

// File: rtl/iwdg_prescaler.sv
// rtl/iwdg_prescaler.sv - free-running clock divider producing one tick every 4<<pr enabled cycles
module iwdg_prescaler
  import iwdg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [PR_W-1:0] pr,
  output logic            tick
);

  logic [PRESC_W-1:0] presc;
  logic [DIV_W-1:0]   div;
  logic [PRESC_W-1:0] last;

  assign div  = pr_to_div(pr);
  assign last = PRESC_W'(div - 9'd1);

  // A clear on the same edge suppresses the tick so restart always wins.
  assign tick = en && !clr && (presc == last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == last) ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/iwdg.sv
// rtl/iwdg.sv - independent watchdog: key decode, config lock, down-counter and reset pulse stretcher
module iwdg
  import iwdg_pkg::*;
#(
  parameter logic [PR_W-1:0]  PR_DEFAULT  = 3'd0,
  parameter logic [RLR_W-1:0] RLR_DEFAULT = 12'hFFF,
  parameter int               RST_LEN     = 4
) (
  input  logic        CLOCK,
  input  logic        i_arstn,
  input  logic        i_sel,
  input  logic [15:0] IWDG_KR,
  input  logic        aCore_signal,
  output logic        Reset_signal
);

  localparam int LEN_W = $clog2(RST_LEN + 1);

  logic             running;
  logic             unlocked;
  logic [PR_W-1:0]  pr_reg;
  logic [PR_W-1:0]  pr_act;
  logic [RLR_W-1:0] rlr;
  logic [RLR_W-1:0] cnt;
  logic [LEN_W-1:0] pulse_left;

  logic key_start;
  logic key_reload;
  logic key_unlock;
  logic key_cfg;
  logic restart;
  logic tick;
  logic expire;

  assign key_start  = i_sel && (IWDG_KR == KEY_START);
  assign key_reload = i_sel && (IWDG_KR == KEY_RELOAD);
  assign key_unlock = i_sel && (IWDG_KR == KEY_UNLOCK);
  assign key_cfg    = i_sel && unlocked && !key_start && !key_reload && !key_unlock;
  assign restart    = key_start || key_reload;
  assign expire     = tick && (cnt == '0);

  iwdg_prescaler u_prescaler (
    .clk  (CLOCK),
    .rst  (i_arstn),
    .en   (running && !aCore_signal),
    .clr  (restart),
    .pr   (pr_act),
    .tick (tick)
  );

  always_ff @(posedge CLOCK) begin
    if (i_arstn) begin
      running      <= 1'b0;
      unlocked     <= 1'b0;
      pr_reg       <= PR_DEFAULT;
      pr_act       <= PR_DEFAULT;
      rlr          <= RLR_DEFAULT;
      cnt          <= RLR_DEFAULT;
      pulse_left   <= '0;
      Reset_signal <= 1'b0;
    end else begin
      if (key_start) running <= 1'b1;

      // Programmed PR only reaches the prescaler at a start or reload.
      if (restart) begin
        cnt    <= rlr;
        pr_act <= pr_reg;
      end else if (tick) begin
        cnt <= (cnt == '0) ? rlr : cnt - 1'b1;
      end

      if (key_reload) begin
        unlocked <= 1'b0;
      end else if (key_unlock) begin
        unlocked <= 1'b1;
      end else if (key_cfg) begin
        pr_reg   <= IWDG_KR[14:12];
        rlr      <= IWDG_KR[11:0];
        unlocked <= 1'b0;
      end

      if (expire) begin
        Reset_signal <= 1'b1;
        pulse_left   <= LEN_W'(RST_LEN - 1);
      end else if (pulse_left != '0) begin
        pulse_left <= pulse_left - 1'b1;
      end else begin
        Reset_signal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iwdg.sv
// tb/tb_iwdg.sv - directed self-checking bench for the independent watchdog
module tb_iwdg;

  logic        CLOCK = 1'b0;
  logic        i_arstn = 1'b1;
  logic        i_sel = 1'b0;
  logic [15:0] IWDG_KR = 16'h0000;
  logic        aCore_signal = 1'b0;
  logic        Reset_signal;

  int checks = 0;
  int errors = 0;

  iwdg dut (
    .CLOCK        (CLOCK),
    .i_arstn      (i_arstn),
    .i_sel        (i_sel),
    .IWDG_KR      (IWDG_KR),
    .aCore_signal (aCore_signal),
    .Reset_signal (Reset_signal)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic do_reset();
    i_arstn = 1'b1;
    i_sel = 1'b0;
    IWDG_KR = 16'h0000;
    aCore_signal = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    i_arstn = 1'b0;
  endtask

  task automatic write_key(input logic [15:0] k);
    i_sel = 1'b1;
    IWDG_KR = k;
    @(posedge CLOCK);
    #1;
    i_sel = 1'b0;
    IWDG_KR = 16'h0000;
  endtask

  // Edges after the current one until Reset_signal is seen high; -1 if never.
  task automatic wait_rise(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit && n < 0; i++) begin
      @(posedge CLOCK);
      #1;
      if (Reset_signal === 1'b1) n = i;
    end
  endtask

  task automatic config_start_fast();
    write_key(16'h5555);
    write_key(16'h0003);
    write_key(16'hCCCC);
  endtask

  task automatic test_reset();
    int highs;
    do_reset();
    checks++;
    if (Reset_signal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0", Reset_signal);
    end
    highs = 0;
    IWDG_KR = 16'hCCCC;
    i_sel = 1'b0;
    repeat (20000) begin
      @(posedge CLOCK);
      #1;
      if (Reset_signal !== 1'b0) highs++;
    end
    IWDG_KR = 16'h0000;
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL no_start_no_reset: high cycles %0d want 0", highs);
    end
  endtask

  task automatic test_timeout();
    logic tr [0:63];
    int rise1, rise2, width;
    do_reset();
    config_start_fast();
    tr[0] = 1'b0;
    for (int n = 1; n < 64; n++) begin
      @(posedge CLOCK);
      #1;
      tr[n] = Reset_signal;
    end
    rise1 = -1;
    rise2 = -1;
    width = 0;
    for (int n = 1; n < 64; n++) begin
      if (tr[n] && !tr[n-1]) begin
        if (rise1 < 0) rise1 = n;
        else if (rise2 < 0) rise2 = n;
      end
    end
    if (rise1 > 0)
      for (int n = rise1; n < 64 && tr[n]; n++) width++;
    checks++;
    if (rise1 !== 16) begin
      errors++;
      $display("FAIL first_timeout: rise at %0d want 16", rise1);
    end
    checks++;
    if (width !== 4) begin
      errors++;
      $display("FAIL pulse_width: %0d want 4", width);
    end
    checks++;
    if (rise2 - rise1 !== 16) begin
      errors++;
      $display("FAIL rearm_period: %0d want 16", rise2 - rise1);
    end
  endtask

  task automatic test_reload_keepalive();
    int highs, n;
    do_reset();
    config_start_fast();
    highs = 0;
    for (int i = 1; i <= 500; i++) begin
      if (i % 10 == 0) begin
        i_sel = 1'b1;
        IWDG_KR = 16'hAAAA;
      end
      @(posedge CLOCK);
      #1;
      i_sel = 1'b0;
      IWDG_KR = 16'h0000;
      if (Reset_signal !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL keepalive: high cycles %0d want 0", highs);
    end

    do_reset();
    config_start_fast();
    repeat (15) @(posedge CLOCK);
    #1;
    write_key(16'hAAAA);
    checks++;
    if (Reset_signal !== 1'b0) begin
      errors++;
      $display("FAIL reload_on_expiry: got %b want 0", Reset_signal);
    end
    wait_rise(40, n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_after_late_reload: rise at %0d want 16", n);
    end
  endtask

  task automatic test_freeze();
    int rise, width;
    do_reset();
    config_start_fast();
    rise = -1;
    for (int k = 1; k <= 60 && rise < 0; k++) begin
      aCore_signal = (k >= 5 && k < 25);
      @(posedge CLOCK);
      #1;
      if (Reset_signal === 1'b1) rise = k;
    end
    checks++;
    if (rise !== 36) begin
      errors++;
      $display("FAIL freeze_timeout: rise at %0d want 36", rise);
    end
    aCore_signal = 1'b1;
    width = 1;
    repeat (8) begin
      @(posedge CLOCK);
      #1;
      if (Reset_signal === 1'b1) width++;
    end
    aCore_signal = 1'b0;
    checks++;
    if (width !== 4) begin
      errors++;
      $display("FAIL pulse_while_frozen: width %0d want 4", width);
    end
  endtask

  task automatic test_lock();
    int n;
    do_reset();
    write_key(16'h0003);
    write_key(16'hCCCC);
    wait_rise(20000, n);
    checks++;
    if (n !== 16384) begin
      errors++;
      $display("FAIL locked_cfg_default_timeout: rise at %0d want 16384", n);
    end
    repeat (5) @(posedge CLOCK);
    #1;
    write_key(16'h5555);
    write_key(16'h1001);
    write_key(16'hAAAA);
    wait_rise(100, n);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL unlocked_cfg_timeout: rise at %0d want 16", n);
    end
  endtask

  task automatic test_prescaler_cap();
    logic [15:0] cfg [0:2];
    int want [0:2];
    int n;
    cfg[0] = 16'h7000; want[0] = 256;
    cfg[1] = 16'h6000; want[1] = 256;
    cfg[2] = 16'h5000; want[2] = 128;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write_key(16'h5555);
      write_key(cfg[i]);
      write_key((i == 0) ? 16'hCCCC : 16'hAAAA);
      wait_rise(400, n);
      checks++;
      if (n !== want[i]) begin
        errors++;
        $display("FAIL prescaler_cfg_%04h: rise at %0d want %0d", cfg[i], n, want[i]);
      end
      repeat (5) @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic test_reset_during_pulse();
    int n, highs;
    do_reset();
    config_start_fast();
    wait_rise(40, n);
    @(posedge CLOCK);
    #1;
    checks++;
    if (Reset_signal !== 1'b1) begin
      errors++;
      $display("FAIL pulse_second_cycle: got %b want 1", Reset_signal);
    end
    i_arstn = 1'b1;
    @(posedge CLOCK);
    #1;
    i_arstn = 1'b0;
    checks++;
    if (Reset_signal !== 1'b0) begin
      errors++;
      $display("FAIL reset_cuts_pulse: got %b want 0", Reset_signal);
    end
    write_key(16'h5555);
    write_key(16'h0003);
    write_key(16'hAAAA);
    highs = 0;
    repeat (64) begin
      @(posedge CLOCK);
      #1;
      if (Reset_signal !== 1'b0) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL stopped_after_reset: high cycles %0d want 0", highs);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_reload_keepalive();
    test_freeze();
    test_lock();
    test_prescaler_cap();
    test_reset_during_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
